// File: rtl/tx_rs232.sv
`timescale 1ns/1ps
// RS232 UART transmitter: 11-bit frame (start, 8 data LSB first, parity or
// second stop, stop). Define TX_RS232_PARITY_EN to put parity in bit 9.
module tx_rs232 #(
  parameter int unsigned CLKS_PER_BIT = 12,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk_s,
  input  logic       rstn_s,
  input  logic [7:0] iDATA,
  input  logic       iSTART,
  output logic       oTXD,
  output logic       oBUSY,
  output logic       oDONE
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_BIT9,
    S_STOP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_clk_q;
  logic [2:0]       cnt_bit_q;
  logic [7:0]       shift_q;
  logic             bit9_q;
  logic             bit9_d;
  logic             txd_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end;

  // Bit 9 is evaluated on the byte being latched, so it reflects the frame's
  // data even though the shift register is consumed during DATA.
  always_comb begin
    bit9_d = 1'b1;
`ifdef TX_RS232_PARITY_EN
    bit9_d = (PARITY_ODD != 0) ? ~^iDATA : ^iDATA;
`else
    // Second stop bit; PARITY_ODD has no effect in this build.
    bit9_d = 1'b1 | (PARITY_ODD != 0);
`endif
  end

  assign bit_end = (cnt_clk_q == CNT_LAST);

  always_ff @(posedge clk_s) begin
    if (!rstn_s) begin
      state_q   <= S_IDLE;
      cnt_clk_q <= '0;
      cnt_bit_q <= '0;
      shift_q   <= '0;
      bit9_q    <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        cnt_clk_q <= bit_end ? '0 : cnt_clk_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (iSTART) begin
            shift_q   <= iDATA;
            bit9_q    <= bit9_d;
            cnt_clk_q <= '0;
            cnt_bit_q <= '0;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            txd_q   <= shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift_q   <= shift_q >> 1;
            cnt_bit_q <= cnt_bit_q + 3'd1;
            if (cnt_bit_q == 3'd7) begin
              txd_q   <= bit9_q;
              state_q <= S_BIT9;
            end else begin
              txd_q <= shift_q[1];
            end
          end
        end
        S_BIT9: begin
          if (bit_end) begin
            txd_q   <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oTXD  = txd_q;
  assign oBUSY = busy_q;
  assign oDONE = done_q;

endmodule

// File: doc/tx_rs232.md
# tx_rs232

UART transmitter for the RS232 link. It serializes one byte per request into an 11-bit frame: start bit, 8 data bits LSB first, a parity bit (or a second stop bit), and a stop bit. The frame format and bit timing match the link's receiver, so the two can be run back-to-back in loopback. It sits between the host-side byte producer and the TXD pad, with a simple start/busy/done handshake.

## Interface
- `CLKS_PER_BIT`, default 12: clock cycles per serial bit.
  - 12 for simulation; 14881 for 9600 bps at 143 MHz.
  - Must be ≥ 2.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Only used when `TX_RS232_PARITY_EN` is defined.
- `clk_s`  in  1  system clock (143 MHz in hardware).
- `rstn_s`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk_s`.
- `iDATA`  in  8  byte to transmit. Sampled only on the cycle a request is accepted.
- `iSTART`  in  1  transmit request. Level-sampled each cycle.
- `oTXD`  out  1  serial line. Idle level is high.
- `oBUSY`  out  1  high while a frame is in progress.
- `oDONE`  out  1  one-cycle pulse at frame completion.

## Operation
- State machine: IDLE → START → DATA → BIT9 → STOP → IDLE.
- Counters:
  - Bit-period counter `cnt_clk`: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Data-bit index `cnt_bit`: counts 0..7, 3 bits.
- IDLE:
  - `oTXD`=1, `oBUSY`=0.
  - If `iSTART`=1, latch `iDATA` into the shift register, clear counters, and go to START.
- START: `oTXD`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `oTXD` = shift-register LSB.
  - At each bit-period end, shift right and increment `cnt_bit`.
  - After bit 7's period, go to BIT9.
- BIT9: drive the parity bit (or the second stop bit, see Configuration) for CLKS_PER_BIT cycles.
- STOP: `oTXD`=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse `oDONE`.
- Requests:
  - `iSTART` while `oBUSY`=1 is ignored. There is no queuing.
  - Changes to `iDATA` during a frame have no effect.
- Parity is computed on the latched byte, never on live `iDATA`.

## Timing
- Reset values:
  - `oTXD`=1, `oBUSY`=0, `oDONE`=0.
  - State IDLE, all counters and the shift register zero.
- Reset has priority over all other conditions.
- Reset asserted mid-frame:
  - On the next edge `oTXD`=1 and `oBUSY`=0.
  - `oDONE` does not pulse.
  - The frame is abandoned.
- Request acceptance: on edge N with `iSTART`=1 in IDLE. From edge N onward, `oTXD`=0 and `oBUSY`=1 (registered outputs).
- Frame length: exactly 11×CLKS_PER_BIT cycles of `oBUSY`=1.
- Bit k of the frame (k=0..10) occupies cycles N+k·CLKS_PER_BIT … N+(k+1)·CLKS_PER_BIT−1.
- Frame end:
  - At edge N+11·CLKS_PER_BIT, `oBUSY` falls and `oDONE`=1 for exactly one cycle.
  - `oTXD` stays 1.
- Back-to-back frames:
  - `iSTART`=1 in the `oDONE` cycle is accepted (state is IDLE).
  - The next start bit begins immediately, with zero idle gap.
- `oDONE` and `oBUSY` are never high in the same cycle.

## Configuration
- Macro: `TX_RS232_PARITY_EN`.
- Defined: BIT9 carries parity.
  - `^data` when `PARITY_ODD`=0.
  - `~^data` when `PARITY_ODD`=1.
- Not defined:
  - BIT9 drives 1, acting as a second stop bit.
  - The parity logic and `PARITY_ODD` are unused.
  - The frame stays 11 bits, so the receiver timing is unchanged.

## Test plan
1. Reset and idle.
   - Stimulus: hold `rstn_s`=0 for 5 cycles, then release with `iSTART`=0 for 50 cycles.
   - Required: `oTXD`=1, `oBUSY`=0, `oDONE`=0 throughout.
2. Even-parity frame.
   - Stimulus: CLKS_PER_BIT=12, macro defined, PARITY_ODD=0, send 0xA5.
   - Required: `oTXD` bit sequence 0,1,0,1,0,0,1,0,1,0,1, each held 12 cycles.
   - Required: `oBUSY` high 132 cycles, then one `oDONE` pulse.
3. Odd parity and macro off.
   - Stimulus: send 0x80 with PARITY_ODD=1.
   - Required: bit 9 = 0.
   - Stimulus: rebuild without the macro and send 0x80.
   - Required: bit 9 = 1.
4. Ignored request and back-to-back frames.
   - Stimulus: pulse `iSTART` with `iDATA`=0xFF at cycle 40 of a 0x00 frame.
   - Required: the frame is unaffected.
   - Stimulus: assert `iSTART` with 0x3C in the `oDONE` cycle.
   - Required: the next start bit begins on the following edge.
5. Reset mid-frame.
   - Stimulus: assert `rstn_s`=0 at cycle 60 of a frame.
   - Required: `oTXD`=1 and `oBUSY`=0 on the next edge, no `oDONE`.
   - Required: the next request transmits normally.
6. Loopback.
   - Stimulus: connect `oTXD` to the receiver input and send 0x00, 0xFF, 0x5A, 0xC3.
   - Required: the receiver reports each byte with its done strobe, in order.
